// File: rtl/r4_control_unit_if.sv
// Control bus between the R4 sequencer and the R4 datapath.
// The sequencer side (master) drives the control pulses and reads RAM and flags.
interface r4_control_unit_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 2
);
  logic                  run;
  logic                  step;
  logic [DATA_WIDTH-1:0] RAM_out;
  logic                  Z_flag;
  logic                  PZ_flag;
  logic                  JMP;
  logic                  Z_JMP;
  logic                  PZ_JMP;
  logic [1:0]            MUX_switch;
  logic                  Acc_button;
  logic                  RAM_button;
  logic                  Output_button;
  logic                  pc_inc;
  logic                  addr_sel;
  logic [ADDR_WIDTH-1:0] operand;
  logic                  halted;
  logic                  branch_taken;

  modport master (
    input  run, step, RAM_out, Z_flag, PZ_flag,
    output JMP, Z_JMP, PZ_JMP, MUX_switch, Acc_button, RAM_button,
           Output_button, pc_inc, addr_sel, operand, halted, branch_taken
  );

  modport slave (
    output run, step, RAM_out, Z_flag, PZ_flag,
    input  JMP, Z_JMP, PZ_JMP, MUX_switch, Acc_button, RAM_button,
           Output_button, pc_inc, addr_sel, operand, halted, branch_taken
  );
endinterface

// File: rtl/r4_control_unit.sv
// R4 instruction sequencer: fetches 4-bit words, decodes them and issues
// single-cycle control pulses to the R4 datapath. All outputs are registered
// and computed from the state being entered, so they line up with the state.
module r4_control_unit #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                timer555,
  input  logic                reset_n,
  r4_control_unit_if.master   bus
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_TFETCH,
    ST_TINC, ST_BRANCH, ST_DONE, ST_HALT
  } state_t;

  localparam logic [1:0] OP_LDA  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_STA  = 2'b10;
  localparam logic [1:0] OP_SYS  = 2'b11;
  localparam logic [1:0] SYS_HLT = 2'b00;
  localparam logic [1:0] SYS_JMP = 2'b01;
  localparam logic [1:0] SYS_BRZ = 2'b10;
  localparam logic [1:0] SYS_BRP = 2'b11;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] ir_reg, ir_next;
  logic [1:0]            op, sub;

  logic                  jmp_reg, jmp_next;
  logic                  z_jmp_reg, z_jmp_next;
  logic                  pz_jmp_reg, pz_jmp_next;
  logic [1:0]            mux_reg, mux_next;
  logic                  acc_btn_reg, acc_btn_next;
  logic                  ram_btn_reg, ram_btn_next;
  logic                  out_btn_reg, out_btn_next;
  logic                  pc_inc_reg, pc_inc_next;
  logic                  addr_sel_reg, addr_sel_next;
  logic [ADDR_WIDTH-1:0] operand_reg, operand_next;
  logic                  halted_reg, halted_next;
  logic                  taken_reg, taken_next;

  assign op  = ir_reg[DATA_WIDTH-1 -: 2];
  assign sub = ir_reg[1:0];

  // State register and instruction register.
  always_ff @(posedge timer555 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ir_reg    <= ir_next;
    end
  end

  // Next-state logic; the instruction word is captured on leaving FETCH.
  always_comb begin
    state_next = state_reg;
    ir_next    = ir_reg;
    case (state_reg)
      ST_IDLE:   if (bus.run || bus.step) state_next = ST_FETCH;
      ST_FETCH: begin
        ir_next    = bus.RAM_out;
        state_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (op != OP_SYS)       state_next = ST_EXEC;
        else if (sub == SYS_HLT) state_next = ST_HALT;
        else                     state_next = ST_TFETCH;
      end
      ST_EXEC:   state_next = ST_DONE;
      ST_TFETCH: state_next = ST_TINC;
      ST_TINC:   state_next = ST_BRANCH;
      ST_BRANCH: state_next = ST_DONE;
      ST_DONE:   state_next = bus.run ? ST_FETCH : ST_IDLE;
      ST_HALT:   state_next = ST_HALT;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output values for the state about to be entered. The accumulator cannot
  // change between TINC and BRANCH, so flags seen on entry equal the flags
  // present during the BRANCH cycle.
  always_comb begin
    jmp_next      = 1'b0;
    z_jmp_next    = 1'b0;
    pz_jmp_next   = 1'b0;
    mux_next      = 2'b00;
    acc_btn_next  = 1'b0;
    ram_btn_next  = 1'b0;
    out_btn_next  = 1'b0;
    pc_inc_next   = 1'b0;
    addr_sel_next = 1'b0;
    operand_next  = operand_reg;
    halted_next   = 1'b0;
    taken_next    = 1'b0;

    // Operand comes from the opcode word, then from the branch target word.
    if (state_reg == ST_FETCH || state_reg == ST_TFETCH)
      operand_next = bus.RAM_out[ADDR_WIDTH-1:0];

    case (state_next)
      ST_DECODE: pc_inc_next = 1'b1;
      ST_EXEC: begin
        addr_sel_next = 1'b1;
        case (op)
          OP_LDA: begin mux_next = 2'b00; acc_btn_next = 1'b1; end
          OP_ADD: begin mux_next = 2'b10; acc_btn_next = 1'b1; end
          OP_STA: begin ram_btn_next = 1'b1; out_btn_next = 1'b1; end
          default: ;
        endcase
      end
      ST_TINC: pc_inc_next = 1'b1;
      ST_BRANCH: begin
        case (sub)
          SYS_JMP: begin jmp_next    = 1'b1; taken_next = 1'b1;        end
          SYS_BRZ: begin z_jmp_next  = 1'b1; taken_next = bus.Z_flag;  end
          SYS_BRP: begin pz_jmp_next = 1'b1; taken_next = bus.PZ_flag; end
          default: ;
        endcase
      end
      ST_HALT: halted_next = 1'b1;
      default: ;
    endcase
  end

  // Registered control outputs; reset drops any pending pulse immediately.
  always_ff @(posedge timer555 or negedge reset_n) begin
    if (!reset_n) begin
      jmp_reg      <= 1'b0;
      z_jmp_reg    <= 1'b0;
      pz_jmp_reg   <= 1'b0;
      mux_reg      <= 2'b00;
      acc_btn_reg  <= 1'b0;
      ram_btn_reg  <= 1'b0;
      out_btn_reg  <= 1'b0;
      pc_inc_reg   <= 1'b0;
      addr_sel_reg <= 1'b0;
      operand_reg  <= '0;
      halted_reg   <= 1'b0;
      taken_reg    <= 1'b0;
    end else begin
      jmp_reg      <= jmp_next;
      z_jmp_reg    <= z_jmp_next;
      pz_jmp_reg   <= pz_jmp_next;
      mux_reg      <= mux_next;
      acc_btn_reg  <= acc_btn_next;
      ram_btn_reg  <= ram_btn_next;
      out_btn_reg  <= out_btn_next;
      pc_inc_reg   <= pc_inc_next;
      addr_sel_reg <= addr_sel_next;
      operand_reg  <= operand_next;
      halted_reg   <= halted_next;
      taken_reg    <= taken_next;
    end
  end

  assign bus.JMP           = jmp_reg;
  assign bus.Z_JMP         = z_jmp_reg;
  assign bus.PZ_JMP        = pz_jmp_reg;
  assign bus.MUX_switch    = mux_reg;
  assign bus.Acc_button    = acc_btn_reg;
  assign bus.RAM_button    = ram_btn_reg;
  assign bus.Output_button = out_btn_reg;
  assign bus.pc_inc        = pc_inc_reg;
  assign bus.addr_sel      = addr_sel_reg;
  assign bus.operand       = operand_reg;
  assign bus.halted        = halted_reg;
  assign bus.branch_taken  = taken_reg;

endmodule
